// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encodings and default width.
package mult_pkg;

  localparam int DEFAULT_N = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: adds (or on the last signed step subtracts) the multiplicand
// and produces the arithmetically shifted accumulator plus the bit retired into mq.
import mult_pkg::*;

module mult_step #(
  parameter int N = DEFAULT_N
) (
  input  logic [N:0]   acc_i,
  input  logic [N-1:0] mcand_i,
  input  logic         mq0_i,
  input  logic         sgn_i,
  input  logic         last_i,
  output logic [N:0]   acc_o,
  output logic         shift_in_o,
  output logic         ret_bit_o
);

  logic [N:0] addend;
  logic [N:0] sum;

  // The multiplier's sign bit carries negative weight, hence the final subtraction.
  always_comb begin
    addend = '0;
    if (mq0_i) begin
      addend = sgn_i ? {mcand_i[N-1], mcand_i} : {1'b0, mcand_i};
    end
    sum        = (sgn_i && last_i) ? (acc_i - addend) : (acc_i + addend);
    acc_o      = {sgn_i & sum[N], sum[N:1]};
    shift_in_o = sum[0];
    ret_bit_o  = sum[0];
  end

endmodule

// File: rtl/shift_add_mult_hs.sv
// Sequential shift-add multiplier with valid/ready handshakes, signed/unsigned mode,
// full 2N-bit parallel product and an LSB-first serial stream of the low product half.
import mult_pkg::*;

module shift_add_mult_hs #(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  input  logic           signed_mode,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           ser_bit,
  output logic           ser_valid
);

  localparam int CNT_W = $clog2(N) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N:0]       acc_q, acc_d;
  logic [N-1:0]     mq_q, mq_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic             sgn_q, sgn_d;
  logic [2*N-1:0]   product_q, product_d;
  logic             out_valid_q, out_valid_d;
  logic             ser_bit_q, ser_bit_d;
  logic             ser_valid_q, ser_valid_d;

  logic [N:0]       step_acc;
  logic             step_shift_in;
  logic             step_ret_bit;
  logic             last_iter;

  assign last_iter = (cnt_q == CNT_W'(N - 1));

  mult_step #(.N(N)) u_step (
    .acc_i      (acc_q),
    .mcand_i    (mcand_q),
    .mq0_i      (mq_q[0]),
    .sgn_i      (sgn_q),
    .last_i     (last_iter),
    .acc_o      (step_acc),
    .shift_in_o (step_shift_in),
    .ret_bit_o  (step_ret_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mq_d        = mq_q;
    mcand_d     = mcand_q;
    sgn_d       = sgn_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    ser_bit_d   = ser_bit_q;
    ser_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mcand_d = multiplicand;
          mq_d    = multiplier;
          acc_d   = '0;
          sgn_d   = signed_mode;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d       = step_acc;
        mq_d        = {step_shift_in, mq_q[N-1:1]};
        ser_bit_d   = step_ret_bit;
        ser_valid_d = 1'b1;
        cnt_d       = cnt_q + CNT_W'(1);
        // The product captures the post-iteration values so DONE is reached on the last step.
        if (last_iter) begin
          product_d   = {step_acc[N-1:0], step_shift_in, mq_q[N-1:1]};
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      ser_valid_d = 1'b0;
      cnt_d       = '0;
      product_d   = product_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mq_q        <= '0;
      mcand_q     <= '0;
      sgn_q       <= 1'b0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mq_q        <= mq_d;
      mcand_q     <= mcand_d;
      sgn_q       <= sgn_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign ser_bit   = ser_bit_q;
  assign ser_valid = ser_valid_q;

endmodule

// File: tb/tb_shift_add_mult_hs.sv
// Directed self-checking bench: an N=8 instance for handshake/flush/reset behaviour and an
// N=32 instance driven back-to-back with hand-computed products.
module tb_shift_add_mult_hs;

  logic clk;
  logic rst_n;

  logic        inValid8, inReady8, signed8, flush8, outValid8, outReady8, serBit8, serValid8;
  logic [7:0]  mcand8, mplier8;
  logic [15:0] product8;

  logic        inValid32, inReady32, signed32, flush32, outValid32, outReady32, serBit32, serValid32;
  logic [31:0] mcand32, mplier32;
  logic [63:0] product32;

  int checks;
  int errors;

  shift_add_mult_hs #(.N(8)) dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (inValid8),
    .in_ready     (inReady8),
    .multiplicand (mcand8),
    .multiplier   (mplier8),
    .signed_mode  (signed8),
    .flush        (flush8),
    .out_valid    (outValid8),
    .out_ready    (outReady8),
    .product      (product8),
    .ser_bit      (serBit8),
    .ser_valid    (serValid8)
  );

  shift_add_mult_hs #(.N(32)) dut32 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (inValid32),
    .in_ready     (inReady32),
    .multiplicand (mcand32),
    .multiplier   (mplier32),
    .signed_mode  (signed32),
    .flush        (flush32),
    .out_valid    (outValid32),
    .out_ready    (outReady32),
    .product      (product32),
    .ser_bit      (serBit32),
    .ser_valid    (serValid32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One N=8 operation: accept, count edges to out_valid, gather the serial stream, then
  // optionally stall the consumer for holdCycles before accepting the product.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic s, input logic [15:0] expected, input int holdCycles);
    int   edges;
    int   serCount;
    logic [7:0] serWord;
    checkOutput({tag, "_in_ready"}, 64'(inReady8), 64'd1);
    inValid8 = 1'b1;
    mcand8   = a;
    mplier8  = b;
    signed8  = s;
    tick();
    inValid8 = 1'b0;
    mcand8   = 8'hXX;
    mplier8  = 8'hXX;
    edges    = 0;
    serCount = 0;
    serWord  = '0;
    while (edges < 20 && !outValid8) begin
      if (serValid8) begin
        if (serCount < 8) serWord[serCount] = serBit8;
        serCount++;
      end
      if (outValid8) break;
      tick();
      edges++;
    end
    if (serValid8) begin
      if (serCount < 8) serWord[serCount] = serBit8;
      serCount++;
    end
    checkOutput({tag, "_latency"}, 64'(edges), 64'd8);
    checkOutput({tag, "_product"}, 64'(product8), 64'(expected));
    checkOutput({tag, "_ser_count"}, 64'(serCount), 64'd8);
    checkOutput({tag, "_ser_word"}, 64'(serWord), 64'(expected[7:0]));
    for (int i = 0; i < holdCycles; i++) begin
      tick();
      checkOutput({tag, "_hold_valid"}, 64'(outValid8), 64'd1);
      checkOutput({tag, "_hold_product"}, 64'(product8), 64'(expected));
      checkOutput({tag, "_hold_in_ready"}, 64'(inReady8), 64'd0);
    end
    outReady8 = 1'b1;
    tick();
    outReady8 = 1'b0;
    checkOutput({tag, "_drained"}, 64'(outValid8), 64'd0);
    checkOutput({tag, "_idle"}, 64'(inReady8), 64'd1);
  endtask

  logic [31:0] vecA [5];
  logic [31:0] vecB [5];
  logic        vecS [5];
  logic [63:0] vecP [5];
  int          acceptCyc [5];

  initial begin
    int quietBad;
    int accepted;
    int results;
    int cyc;
    logic accepting;

    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    inValid8   = 1'b0;  mcand8  = '0; mplier8  = '0; signed8  = 1'b0; flush8  = 1'b0; outReady8  = 1'b0;
    inValid32  = 1'b0;  mcand32 = '0; mplier32 = '0; signed32 = 1'b0; flush32 = 1'b0; outReady32 = 1'b0;

    tick();
    tick();
    checkOutput("reset_out_valid", 64'(outValid8), 64'd0);
    checkOutput("reset_product", 64'(product8), 64'd0);
    checkOutput("reset_ser_valid", 64'(serValid8), 64'd0);
    checkOutput("reset_ser_bit", 64'(serBit8), 64'd0);
    checkOutput("reset_in_ready", 64'(inReady8), 64'd1);
    checkOutput("reset_product32", product32, 64'd0);
    rst_n = 1'b1;
    tick();

    applyStimulus("u3x5", 8'd3, 8'd5, 1'b0, 16'h000F, 0);
    applyStimulus("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
    applyStimulus("sMinxMin", 8'h80, 8'h80, 1'b1, 16'h4000, 0);
    applyStimulus("sm3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 0);
    applyStimulus("u7x0", 8'd7, 8'd0, 1'b0, 16'h0000, 0);
    applyStimulus("stall", 8'd12, 8'd10, 1'b0, 16'h0078, 5);

    // Abort mid-run: out_valid must stay low and the product keeps its previous value.
    inValid8 = 1'b1; mcand8 = 8'd9; mplier8 = 8'd9; signed8 = 1'b0;
    tick();
    inValid8 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    flush8 = 1'b1;
    tick();
    flush8 = 1'b0;
    checkOutput("flush_in_ready", 64'(inReady8), 64'd1);
    checkOutput("flush_ser_valid", 64'(serValid8), 64'd0);
    checkOutput("flush_product_kept", 64'(product8), 64'h0078);
    quietBad = 0;
    for (int i = 0; i < 12; i++) begin
      if (outValid8 || !inReady8) quietBad++;
      tick();
    end
    checkOutput("flush_quiet", 64'(quietBad), 64'd0);

    inValid8 = 1'b1; flush8 = 1'b1; mcand8 = 8'd2; mplier8 = 8'd2;
    tick();
    inValid8 = 1'b0; flush8 = 1'b0;
    checkOutput("flush_wins_accept", 64'(inReady8), 64'd1);
    checkOutput("flush_wins_ser", 64'(serValid8), 64'd0);

    applyStimulus("after_flush6x7", 8'd6, 8'd7, 1'b0, 16'h002A, 0);

    // Reset in the middle of an operation.
    inValid8 = 1'b1; mcand8 = 8'd11; mplier8 = 8'd13; signed8 = 1'b0;
    tick();
    inValid8 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_out_valid", 64'(outValid8), 64'd0);
    checkOutput("midrst_product", 64'(product8), 64'd0);
    checkOutput("midrst_ser_valid", 64'(serValid8), 64'd0);
    checkOutput("midrst_ser_bit", 64'(serBit8), 64'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("midrst_in_ready", 64'(inReady8), 64'd1);

    // N=32 back-to-back with in_valid and out_ready held high.
    vecA[0] = 32'hFFFFFFFF; vecB[0] = 32'hFFFFFFFF; vecS[0] = 1'b0; vecP[0] = 64'hFFFFFFFE_00000001;
    vecA[1] = 32'h80000000; vecB[1] = 32'h80000000; vecS[1] = 1'b1; vecP[1] = 64'h40000000_00000000;
    vecA[2] = 32'hFFFFFFFF; vecB[2] = 32'h00000001; vecS[2] = 1'b1; vecP[2] = 64'hFFFFFFFF_FFFFFFFF;
    vecA[3] = 32'h00010000; vecB[3] = 32'h00010000; vecS[3] = 1'b0; vecP[3] = 64'h00000001_00000000;
    vecA[4] = 32'h7FFFFFFF; vecB[4] = 32'h80000000; vecS[4] = 1'b1; vecP[4] = 64'hC0000000_80000000;

    accepted   = 0;
    results    = 0;
    cyc        = 0;
    outReady32 = 1'b1;
    inValid32  = 1'b1;
    mcand32 = vecA[0]; mplier32 = vecB[0]; signed32 = vecS[0];
    while (cyc < 400 && results < 5) begin
      accepting = inValid32 && inReady32;
      tick();
      cyc++;
      if (accepting) begin
        acceptCyc[accepted] = cyc;
        accepted++;
        if (accepted < 5) begin
          mcand32 = vecA[accepted]; mplier32 = vecB[accepted]; signed32 = vecS[accepted];
        end else begin
          inValid32 = 1'b0;
        end
      end
      if (outValid32) begin
        checkOutput($sformatf("n32_product%0d", results), product32, vecP[results]);
        results++;
      end
    end
    outReady32 = 1'b0;
    checkOutput("n32_result_count", 64'(results), 64'd5);
    for (int i = 1; i < 5; i++) begin
      if (i < accepted)
        checkOutput($sformatf("n32_interval%0d", i), 64'(acceptCyc[i] - acceptCyc[i-1]), 64'd34);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
